stopwatch_control: RTL

Front-end control stage of the stopwatch datapath. Debounces the raw run/stop and clear push-buttons and runs a three-state IDLE/RUN/PAUSE machine. Divides the system clock into a single-cycle `increment` tick that drives the first (least-significant) mod counter of the digit chain. Also issues a single-cycle `clear` pulse that drives the synchronous reset of every counter stage.

---
 rtl/stopwatch_control.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_control.sv
// Stopwatch front-end: button synchronizers and debouncers, IDLE/RUN/PAUSE control FSM,
// and the divider that produces the increment tick for the least-significant counter stage.
module stopwatch_control #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int TICK_DIVIDE     = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_run,
   input  logic btn_clear,
   output logic increment,
   output logic clear,
   output logic running
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TW = $clog2(TICK_DIVIDE);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIVIDE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   // Bit 0 carries the run button, bit 1 the clear button.
   logic [1:0]    s1;
   logic [1:0]    s2;
   logic [1:0]    stable;
   logic [1:0]    stable_d;
   logic [DW-1:0] deb_cnt [2];

   logic run_press;
   logic clear_press;

   state_t        state;
   state_t        next_state;
   logic [TW-1:0] div;
   logic [TW-1:0] div_next;
   logic          tick_next;
   logic          clear_next;
   logic          running_next;

   // A level is accepted only after it has disagreed with stable for DEBOUNCE_CYCLES edges in a row.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1       <= '0;
         s2       <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 2; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         s1       <= {btn_clear, btn_run};
         s2       <= s1;
         stable_d <= stable;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == stable[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_LAST) begin
               stable[i]  <= s2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + DW'(1);
            end
         end
      end
   end

   assign run_press   = stable[0] & ~stable_d[0];
   assign clear_press = stable[1] & ~stable_d[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         div       <= '0;
         increment <= 1'b0;
         clear     <= 1'b0;
         running   <= 1'b0;
      end else begin
         state     <= next_state;
         div       <= div_next;
         increment <= tick_next;
         clear     <= clear_next;
         running   <= running_next;
      end
   end

   // Clear outranks run everywhere except RUN, where clear is not honoured at all.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (clear_press) begin
               next_state = IDLE;
            end else if (run_press) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (run_press) begin
               next_state = PAUSE;
            end
         end
         PAUSE: begin
            if (clear_press) begin
               next_state = IDLE;
            end else if (run_press) begin
               next_state = RUN;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // The divider still advances on the edge that leaves RUN, but that edge never emits a tick.
   always_comb begin
      div_next     = div;
      tick_next    = 1'b0;
      clear_next   = 1'b0;
      running_next = (next_state == RUN);
      case (state)
         IDLE: begin
            div_next   = '0;
            clear_next = clear_press;
         end
         RUN: begin
            if (div == DIV_LAST) begin
               div_next  = '0;
               tick_next = (next_state == RUN);
            end else begin
               div_next = div + TW'(1);
            end
         end
         PAUSE: begin
            if (clear_press) begin
               div_next   = '0;
               clear_next = 1'b1;
            end
         end
         default: div_next = '0;
      endcase
   end

endmodule
